reset_sequencer: RTL and testbench

Sequences clock and reset bring-up for the design. It holds the PLL in reset after power-on, waits for a stable `pll_lock`, then releases a set of reset domains one at a time in a fixed order. It also re-asserts every domain on loss of lock and services soft-reset requests from software. It sits between the debounced board reset and every downstream reset consumer.

---
 rtl/reset_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Clock/reset bring-up sequencer: PLL reset pulse, lock wait and settle, ordered domain release, soft reset, lock-loss handling.
// Optional lock-wait timeout with PLL retry is enabled by defining RESET_SEQ_LOCK_TIMEOUT_EN.
module reset_sequencer #(
    parameter int NUM_DOMAINS    = 4,
    parameter int STAGE_DELAY    = 255,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 4095
) (
    input  logic                   clk,
    input  logic                   NRST,
    input  logic                   pll_lock,
    input  logic                   soft_rst_req,
    output logic                   soft_rst_ack,
    output logic                   pll_reset,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   seq_done,
    output logic [7:0]             lock_loss_cnt,
    output logic [7:0]             timeout_cnt
);

    localparam int MAX_A = (STAGE_DELAY > PLL_RST_CYCLES) ? STAGE_DELAY : PLL_RST_CYCLES;
    localparam int MAX_B = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int CNT_W = $clog2(MAX_B) + 1;
    localparam int IDX_W = $clog2(NUM_DOMAINS + 1);

    localparam logic [CNT_W-1:0] PLL_LAST   = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_RELEASE,
        ST_RUN,
        ST_SOFT
    } state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic                   pll_reset_reg, pll_reset_next;
    logic [NUM_DOMAINS-1:0] domain_rst_reg, domain_rst_next;
    logic                   seq_done_reg, seq_done_next;
    logic                   ack_reg, ack_next;
    logic [7:0]             lock_loss_reg, lock_loss_next;
    logic [NUM_DOMAINS-1:0] release_mask;

    // One-hot select of the domain released on the next release step.
    generate
        for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_release_mask
            assign release_mask[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    logic [7:0] timeout_reg, timeout_next;
`endif

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg + 1'b1;
        idx_next        = idx_reg;
        pll_reset_next  = pll_reset_reg;
        domain_rst_next = domain_rst_reg;
        seq_done_next   = seq_done_reg;
        ack_next        = 1'b0;
        lock_loss_next  = lock_loss_reg;
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
        timeout_next    = timeout_reg;
`endif

        case (state_reg)
            ST_PLL_RST: begin
                pll_reset_next = 1'b1;
                if (cnt_reg == PLL_LAST) begin
                    state_next     = ST_WAIT_LOCK;
                    cnt_next       = '0;
                    pll_reset_next = 1'b0;
                end
            end

            ST_WAIT_LOCK: begin
                if (pll_lock) begin
                    state_next = ST_SETTLE;
                    cnt_next   = '0;
                end
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
                else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next     = ST_PLL_RST;
                    cnt_next       = '0;
                    pll_reset_next = 1'b1;
                    timeout_next   = (timeout_reg == 8'hFF) ? timeout_reg : timeout_reg + 8'd1;
                end
`else
                else begin
                    cnt_next = '0;
                end
`endif
            end

            ST_SETTLE: begin
                // A lock drop before any domain is released only restarts the settle wait.
                if (!pll_lock) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt_reg == STAGE_LAST) begin
                    cnt_next = '0;
                    if (NUM_DOMAINS == 1) begin
                        state_next      = ST_RUN;
                        domain_rst_next = '0;
                        seq_done_next   = 1'b1;
                    end else begin
                        state_next      = ST_RELEASE;
                        domain_rst_next = domain_rst_reg & ~NUM_DOMAINS'(1);
                        idx_next        = IDX_W'(1);
                    end
                end
            end

            ST_RELEASE: begin
                if (!pll_lock) begin
                    state_next      = ST_WAIT_LOCK;
                    cnt_next        = '0;
                    idx_next        = '0;
                    domain_rst_next = '1;
                    seq_done_next   = 1'b0;
                    lock_loss_next  = (lock_loss_reg == 8'hFF) ? lock_loss_reg : lock_loss_reg + 8'd1;
                end else if (cnt_reg == STAGE_LAST) begin
                    cnt_next        = '0;
                    domain_rst_next = domain_rst_reg & ~release_mask;
                    idx_next        = idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        state_next    = ST_RUN;
                        seq_done_next = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                cnt_next = '0;
                if (!pll_lock) begin
                    state_next      = ST_WAIT_LOCK;
                    idx_next        = '0;
                    domain_rst_next = '1;
                    seq_done_next   = 1'b0;
                    lock_loss_next  = (lock_loss_reg == 8'hFF) ? lock_loss_reg : lock_loss_reg + 8'd1;
                end else if (soft_rst_req) begin
                    state_next      = ST_SOFT;
                    idx_next        = '0;
                    domain_rst_next = '1;
                    seq_done_next   = 1'b0;
                end
            end

            ST_SOFT: begin
                // Losing lock here abandons the soft reset without an acknowledge.
                if (!pll_lock) begin
                    state_next      = ST_WAIT_LOCK;
                    cnt_next        = '0;
                    idx_next        = '0;
                    domain_rst_next = '1;
                    seq_done_next   = 1'b0;
                    lock_loss_next  = (lock_loss_reg == 8'hFF) ? lock_loss_reg : lock_loss_reg + 8'd1;
                end else if (cnt_reg == STAGE_LAST) begin
                    state_next = ST_SETTLE;
                    cnt_next   = '0;
                    ack_next   = 1'b1;
                end
            end

            default: begin
                state_next      = ST_PLL_RST;
                cnt_next        = '0;
                idx_next        = '0;
                pll_reset_next  = 1'b1;
                domain_rst_next = '1;
                seq_done_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!NRST) begin
            state_reg      <= ST_PLL_RST;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            pll_reset_reg  <= 1'b1;
            domain_rst_reg <= '1;
            seq_done_reg   <= 1'b0;
            ack_reg        <= 1'b0;
            lock_loss_reg  <= 8'd0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            pll_reset_reg  <= pll_reset_next;
            domain_rst_reg <= domain_rst_next;
            seq_done_reg   <= seq_done_next;
            ack_reg        <= ack_next;
            lock_loss_reg  <= lock_loss_next;
        end
    end

`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!NRST) begin
            timeout_reg <= 8'd0;
        end else begin
            timeout_reg <= timeout_next;
        end
    end
    assign timeout_cnt = timeout_reg;
`else
    assign timeout_cnt = 8'd0;
`endif

    assign soft_rst_ack  = ack_reg;
    assign pll_reset     = pll_reset_reg;
    assign domain_rst    = domain_rst_reg;
    assign seq_done      = seq_done_reg;
    assign lock_loss_cnt = lock_loss_reg;

    // Released domains always form a contiguous low-order group.
    a_release_order: assert property (@(posedge clk) disable iff (!NRST)
        ((domain_rst_reg << 1) & ~domain_rst_reg) == '0);
    a_done_means_released: assert property (@(posedge clk) disable iff (!NRST)
        seq_done_reg |-> (domain_rst_reg == '0));
    a_pll_reset_holds_domains: assert property (@(posedge clk) disable iff (!NRST)
        pll_reset_reg |-> (&domain_rst_reg));

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timeline-based reference model checked every cycle, plus directed literal checks.
// Edge numbering: edge 0 is the last edge that samples NRST low; later edges count up from there.
module tb_reset_sequencer;

    localparam int N   = 4;
    localparam int SD  = 8;
    localparam int PRC = 4;
    localparam int LT  = 32;

    logic         clk;
    logic         NRST;
    logic         pll_lock;
    logic         soft_rst_req;
    logic         soft_rst_ack;
    logic         pll_reset;
    logic [N-1:0] domain_rst;
    logic         seq_done;
    logic [7:0]   lock_loss_cnt;
    logic [7:0]   timeout_cnt;

    reset_sequencer #(
        .NUM_DOMAINS   (N),
        .STAGE_DELAY   (SD),
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT  (LT)
    ) dut (
        .clk          (clk),
        .NRST         (NRST),
        .pll_lock     (pll_lock),
        .soft_rst_req (soft_rst_req),
        .soft_rst_ack (soft_rst_ack),
        .pll_reset    (pll_reset),
        .domain_rst   (domain_rst),
        .seq_done     (seq_done),
        .lock_loss_cnt(lock_loss_cnt),
        .timeout_cnt  (timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int e        = 0;

    // Model: phase 0 = PLL reset pulse, 1 = waiting for lock, 2 = lock held (settle + releases + run),
    // 3 = soft reset hold. t0 is the edge at which the current phase began.
    int           ph    = 0;
    int           t0    = 0;
    int           llc   = 0;
    int           toc   = 0;
    bit           ack   = 0;
    bit           mvalid = 0;
    logic [N-1:0] ones  = '1;
    logic         exp_pll;
    logic [N-1:0] exp_dom;
    logic         exp_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, e, act, expv);
        end
    endtask

    // Number of domains released when the lock has been held for d edges since the lock edge.
    function automatic int released(input int d);
        int r;
        if (d < 0) return 0;
        r = d / SD;
        return (r > N) ? N : r;
    endfunction

    task automatic model_step();
        int age;
        int nprev;
        int n;
        if (!NRST) begin
            e = 0; ph = 0; t0 = 0; llc = 0; toc = 0; ack = 0; mvalid = 1;
        end else begin
            e++;
            ack = 0;
            age = e - t0;
            case (ph)
                0: if (age == PRC) begin ph = 1; t0 = e; end
                1: begin
                    if (pll_lock) begin
                        ph = 2; t0 = e;
                    end
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
                    else if (age == LT) begin
                        ph = 0; t0 = e;
                        if (toc < 255) toc++;
                    end
`endif
                end
                2: begin
                    nprev = released(e - 1 - t0);
                    if (!pll_lock) begin
                        if (nprev > 0 && llc < 255) llc++;
                        ph = 1; t0 = e;
                    end else if (nprev == N && soft_rst_req) begin
                        ph = 3; t0 = e;
                    end
                end
                default: begin
                    if (!pll_lock) begin
                        if (llc < 255) llc++;
                        ph = 1; t0 = e;
                    end else if (age == SD) begin
                        ack = 1; ph = 2; t0 = e;
                    end
                end
            endcase
        end
        n        = (ph == 2) ? released(e - t0) : 0;
        exp_pll  = (ph == 0);
        exp_dom  = ones << n;
        exp_done = (ph == 2) && (n == N);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (mvalid) begin
            check("pll_reset",     32'(pll_reset),     32'(exp_pll));
            check("domain_rst",    32'(domain_rst),    32'(exp_dom));
            check("seq_done",      32'(seq_done),      32'(exp_done));
            check("soft_rst_ack",  32'(soft_rst_ack),  32'(ack));
            check("lock_loss_cnt", 32'(lock_loss_cnt), llc);
            check("timeout_cnt",   32'(timeout_cnt),   toc);
        end
    end

    task automatic goto_edge(input int n);
        while (e < n) @(negedge clk);
    endtask

    task automatic note(input string msg);
        $display("[edge %0d] %s", e, msg);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_reset"},  32'(pll_reset),     32'd1);
        check({tag, "_domain_rst"}, 32'(domain_rst),    32'hF);
        check({tag, "_seq_done"},   32'(seq_done),      32'd0);
        check({tag, "_ack"},        32'(soft_rst_ack),  32'd0);
        check({tag, "_llc"},        32'(lock_loss_cnt), 32'd0);
        check({tag, "_toc"},        32'(timeout_cnt),   32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", e);
        $fatal(1, "watchdog");
    end

    initial begin
        NRST = 1'b0; pll_lock = 1'b0; soft_rst_req = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        note("power-on reset values");
        NRST = 1'b1;

        // Bring-up
        goto_edge(3);  check("bringup_pll_hi", 32'(pll_reset), 32'd1);
        goto_edge(4);  check("bringup_pll_lo", 32'(pll_reset), 32'd0);
        note("pll_reset released");
        goto_edge(9);  pll_lock = 1'b1;
        goto_edge(17); check("bringup_d17", 32'(domain_rst), 32'hF);
        goto_edge(18); check("bringup_d18", 32'(domain_rst), 32'hE);
        goto_edge(26); check("bringup_d26", 32'(domain_rst), 32'hC);
        goto_edge(34); check("bringup_d34", 32'(domain_rst), 32'h8);
        goto_edge(41); check("bringup_done41", 32'(seq_done), 32'd0);
        goto_edge(42); check("bringup_d42", 32'(domain_rst), 32'h0);
        check("bringup_done42", 32'(seq_done), 32'd1);
        note("bring-up complete");

        // Soft reset, S = 51
        goto_edge(50); soft_rst_req = 1'b1;
        goto_edge(51); soft_rst_req = 1'b0;
        check("soft_assert", 32'(domain_rst), 32'hF);
        check("soft_done_lo", 32'(seq_done), 32'd0);
        goto_edge(59); check("soft_ack_hi", 32'(soft_rst_ack), 32'd1);
        goto_edge(60); check("soft_ack_lo", 32'(soft_rst_ack), 32'd0);
        goto_edge(66); check("soft_d66", 32'(domain_rst), 32'hF);
        goto_edge(67); check("soft_d67", 32'(domain_rst), 32'hE);
        goto_edge(91); check("soft_done91", 32'(seq_done), 32'd1);
        note("soft reset complete");

        // Lock loss in RUN, relock at 106, glitch in SETTLE at 109
        goto_edge(100); pll_lock = 1'b0;
        goto_edge(101);
        check("loss_dom", 32'(domain_rst), 32'hF);
        check("loss_done", 32'(seq_done), 32'd0);
        check("loss_llc", 32'(lock_loss_cnt), 32'd1);
        goto_edge(105); pll_lock = 1'b1;
        goto_edge(108); pll_lock = 1'b0;
        goto_edge(109); pll_lock = 1'b1;
        goto_edge(117); check("glitch_d117", 32'(domain_rst), 32'hF);
        goto_edge(118); check("glitch_d118", 32'(domain_rst), 32'hE);
        check("glitch_llc", 32'(lock_loss_cnt), 32'd1);
        goto_edge(142); check("relock_done", 32'(seq_done), 32'd1);
        note("lock loss and settle glitch handled");

        // Lock drop during SOFT: no ack
        goto_edge(150); soft_rst_req = 1'b1;
        goto_edge(151); soft_rst_req = 1'b0;
        goto_edge(155); pll_lock = 1'b0;
        goto_edge(156); check("softloss_llc", 32'(lock_loss_cnt), 32'd2);
        goto_edge(159); check("softloss_ack159", 32'(soft_rst_ack), 32'd0);
        pll_lock = 1'b1;
        goto_edge(160); check("softloss_ack160", 32'(soft_rst_ack), 32'd0);
        goto_edge(192); check("softloss_done", 32'(seq_done), 32'd1);
        note("soft reset aborted by lock loss");

        // Request held high across RUN re-entry
        goto_edge(195); soft_rst_req = 1'b1;
        goto_edge(204); check("held_ack", 32'(soft_rst_ack), 32'd1);
        goto_edge(236); check("held_done236", 32'(seq_done), 32'd1);
        goto_edge(237); check("held_done237", 32'(seq_done), 32'd0);
        check("held_dom237", 32'(domain_rst), 32'hF);
        soft_rst_req = 1'b0;
        note("held request restarted soft reset");

        // Timeout behaviour with lock held low
        goto_edge(280); pll_lock = 1'b0;
        goto_edge(281); check("to_llc", 32'(lock_loss_cnt), 32'd3);
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
        goto_edge(312); check("to_pll312", 32'(pll_reset), 32'd0);
        goto_edge(313); check("to_pll313", 32'(pll_reset), 32'd1);
        check("to_cnt313", 32'(timeout_cnt), 32'd1);
        goto_edge(317); check("to_pll317", 32'(pll_reset), 32'd0);
        goto_edge(349); check("to_cnt349", 32'(timeout_cnt), 32'd2);
        check("to_pll349", 32'(pll_reset), 32'd1);
        goto_edge(9500); check("to_sat", 32'(timeout_cnt), 32'd255);
`else
        goto_edge(313); check("to_pll313", 32'(pll_reset), 32'd0);
        check("to_cnt313", 32'(timeout_cnt), 32'd0);
        goto_edge(9500); check("to_cnt9500", 32'(timeout_cnt), 32'd0);
`endif
        note("lock timeout behaviour");

        // Relock, then NRST during RELEASE
        pll_lock = 1'b1;
        goto_edge(9517); check("mid_d9517", 32'(domain_rst), 32'hC);
        goto_edge(9519); NRST = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
        note("mid-sequence reset");
        NRST = 1'b1;
        goto_edge(4);  check("rebring_pll", 32'(pll_reset), 32'd0);
        goto_edge(13); check("rebring_d13", 32'(domain_rst), 32'hE);
        goto_edge(37); check("rebring_done", 32'(seq_done), 32'd1);
        note("re-bring-up after reset");

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
